// File: rtl/captura_teclado.sv
// captura_teclado: keypad capture front-end for a cash terminal.
// Once a card is present it forwards four PIN digits to the controller.
// It then builds a decimal amount from digit keys and hands it over in binary
// when the ENTER key is pressed. Only one transaction is allowed per card
// insertion.
//
// Ports
//   clk              : single clock, rising edge
//   rst              : synchronous active-high reset
//   tarjeta_recibida : card present; low aborts any session
//   tecla[3:0]       : raw keypad code (0-9 digits, A-F control)
//   tecla_stb        : one-cycle strobe qualifying tecla
//   digito[3:0]      : PIN digit forwarded to the controller
//   digito_stb       : one-cycle strobe qualifying digito
//   monto[31:0]      : committed binary amount, held until the next commit
//   monto_stb        : one-cycle strobe qualifying monto
//   tecla_invalida   : one-cycle pulse flagging a rejected key
//   estado[1:0]      : current state (ESPERA=0, PIN=1, MONTO=2)
module captura_teclado #(
  parameter logic [3:0] TECLA_ENTER  = 4'hE,
  parameter logic [3:0] TECLA_BORRAR = 4'hC,
  parameter int         MAX_DIGITOS  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tarjeta_recibida,
  input  logic [3:0]  tecla,
  input  logic        tecla_stb,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        tecla_invalida,
  output logic [1:0]  estado
);

  localparam int CW = $clog2(MAX_DIGITOS + 1);

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    PIN    = 2'd1,
    MONTO  = 2'd2
  } estado_t;

  estado_t        estado_r, estado_s;
  logic [2:0]     cnt_pin_r, cnt_pin_s;
  logic [CW-1:0]  cnt_monto_r, cnt_monto_s;
  logic [31:0]    acc_r, acc_s;
  logic [31:0]    monto_r, monto_s;
  logic [3:0]     digito_r, digito_s;
  logic           digito_stb_r, digito_stb_s;
  logic           monto_stb_r, monto_stb_s;
  logic           invalida_r, invalida_s;
  // armado: a new session may start; cleared by a commit and re-set only
  // when the card is removed, so one insertion yields one transaction.
  logic           armado_r, armado_s;
  logic           es_digito_s;

  assign es_digito_s    = (tecla <= 4'd9);
  assign estado         = estado_r;
  assign digito         = digito_r;
  assign digito_stb     = digito_stb_r;
  assign monto          = monto_r;
  assign monto_stb      = monto_stb_r;
  assign tecla_invalida = invalida_r;

  // Next-state and next-output logic; all strobes default low.
  always_comb begin
    estado_s     = estado_r;
    cnt_pin_s    = cnt_pin_r;
    cnt_monto_s  = cnt_monto_r;
    acc_s        = acc_r;
    monto_s      = monto_r;
    digito_s     = digito_r;
    digito_stb_s = 1'b0;
    monto_stb_s  = 1'b0;
    invalida_s   = 1'b0;
    armado_s     = armado_r;

    if (!tarjeta_recibida) begin
      armado_s = 1'b1;
    end else begin
      armado_s = armado_r;
    end

    case (estado_r)
      ESPERA: begin
        if (tarjeta_recibida && armado_r) begin
          estado_s = PIN;
        end else begin
          estado_s = ESPERA;
        end
      end

      PIN: begin
        // Card removal wins over any same-cycle key, which is dropped silently.
        if (!tarjeta_recibida) begin
          estado_s    = ESPERA;
          cnt_pin_s   = 3'd0;
          cnt_monto_s = '0;
          acc_s       = 32'd0;
        end else if (tecla_stb) begin
          if (es_digito_s) begin
            digito_s     = tecla;
            digito_stb_s = 1'b1;
            if (cnt_pin_r == 3'd3) begin
              estado_s  = MONTO;
              cnt_pin_s = 3'd0;
            end else begin
              cnt_pin_s = cnt_pin_r + 3'd1;
            end
          end else begin
            invalida_s = 1'b1;
          end
        end else begin
          estado_s = PIN;
        end
      end

      MONTO: begin
        if (!tarjeta_recibida) begin
          estado_s    = ESPERA;
          cnt_pin_s   = 3'd0;
          cnt_monto_s = '0;
          acc_s       = 32'd0;
        end else if (tecla_stb) begin
          if (tecla == TECLA_ENTER) begin
            // An empty amount cannot be committed.
            if (cnt_monto_r != '0) begin
              monto_s     = acc_r;
              monto_stb_s = 1'b1;
              estado_s    = ESPERA;
              acc_s       = 32'd0;
              cnt_monto_s = '0;
              armado_s    = 1'b0;
            end else begin
              invalida_s = 1'b1;
            end
          end else if (tecla == TECLA_BORRAR) begin
            acc_s       = 32'd0;
            cnt_monto_s = '0;
          end else if (es_digito_s) begin
            if (cnt_monto_r == CW'(MAX_DIGITOS)) begin
              invalida_s = 1'b1;
            end else begin
              acc_s       = acc_r * 32'd10 + {28'd0, tecla};
              cnt_monto_s = cnt_monto_r + CW'(1);
            end
          end else begin
            invalida_s = 1'b1;
          end
        end else begin
          estado_s = MONTO;
        end
      end

      default: begin
        estado_s    = ESPERA;
        cnt_pin_s   = 3'd0;
        cnt_monto_s = '0;
        acc_s       = 32'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r     <= ESPERA;
      cnt_pin_r    <= 3'd0;
      cnt_monto_r  <= '0;
      acc_r        <= 32'd0;
      monto_r      <= 32'd0;
      digito_r     <= 4'd0;
      digito_stb_r <= 1'b0;
      monto_stb_r  <= 1'b0;
      invalida_r   <= 1'b0;
      armado_r     <= 1'b1;
    end else begin
      estado_r     <= estado_s;
      cnt_pin_r    <= cnt_pin_s;
      cnt_monto_r  <= cnt_monto_s;
      acc_r        <= acc_s;
      monto_r      <= monto_s;
      digito_r     <= digito_s;
      digito_stb_r <= digito_stb_s;
      monto_stb_r  <= monto_stb_s;
      invalida_r   <= invalida_s;
      armado_r     <= armado_s;
    end
  end

endmodule

// File: tb/tb_captura_teclado.sv
// Directed table-driven bench for captura_teclado. Each record is applied for
// one clock cycle; the outputs are compared 1 ns after that rising edge.
module tb_captura_teclado;

  logic        clk;
  logic        rst;
  logic        tarjeta_recibida;
  logic [3:0]  tecla;
  logic        tecla_stb;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        tecla_invalida;
  logic [1:0]  estado;

  int total;
  int bad;

  typedef struct {
    logic        rst;
    logic        card;
    logic        stb;
    logic [3:0]  key;
    logic [1:0]  e_est;
    logic        e_dstb;
    logic [3:0]  e_dig;
    logic        e_mstb;
    logic [31:0] e_monto;
    logic        e_inv;
  } vec_t;

  vec_t vecs[$];

  captura_teclado dut (
    .clk              (clk),
    .rst              (rst),
    .tarjeta_recibida (tarjeta_recibida),
    .tecla            (tecla),
    .tecla_stb        (tecla_stb),
    .digito           (digito),
    .digito_stb       (digito_stb),
    .monto            (monto),
    .monto_stb        (monto_stb),
    .tecla_invalida   (tecla_invalida),
    .estado           (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic c, input logic s, input logic [3:0] k,
                     input logic [1:0] est, input logic dstb, input logic [3:0] dig,
                     input logic mstb, input logic [31:0] mon, input logic inv);
    vec_t v;
    v.rst = r; v.card = c; v.stb = s; v.key = k;
    v.e_est = est; v.e_dstb = dstb; v.e_dig = dig;
    v.e_mstb = mstb; v.e_monto = mon; v.e_inv = inv;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return 1 ns after the rising edge.
  task automatic step(input logic r, input logic c, input logic s, input logic [3:0] k);
    @(negedge clk);
    rst = r; tarjeta_recibida = c; tecla_stb = s; tecla = k;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] est, input logic dstb,
                         input logic [3:0] dig, input logic mstb, input logic [31:0] mon,
                         input logic inv);
    chk({tag, ".estado"}, {30'd0, estado}, {30'd0, est});
    chk({tag, ".digito_stb"}, {31'd0, digito_stb}, {31'd0, dstb});
    chk({tag, ".digito"}, {28'd0, digito}, {28'd0, dig});
    chk({tag, ".monto_stb"}, {31'd0, monto_stb}, {31'd0, mstb});
    chk({tag, ".monto"}, monto, mon);
    chk({tag, ".tecla_invalida"}, {31'd0, tecla_invalida}, {31'd0, inv});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; tarjeta_recibida = 1'b0; tecla_stb = 1'b0; tecla = 4'd0;

    //   rst  card stb key    est   dstb dig   mstb monto         inv
    add(1'b1,1'b0,1'b0,4'h0, 2'd0,1'b0,4'd0,1'b0,32'd0,        1'b0); // reset
    add(1'b0,1'b1,1'b0,4'h0, 2'd1,1'b0,4'd0,1'b0,32'd0,        1'b0); // card in
    add(1'b0,1'b1,1'b1,4'h3, 2'd1,1'b1,4'd3,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'h7, 2'd1,1'b1,4'd7,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'hB, 2'd1,1'b0,4'd7,1'b0,32'd0,        1'b1); // bad PIN key
    add(1'b0,1'b1,1'b1,4'h2, 2'd1,1'b1,4'd2,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'h1, 2'd2,1'b1,4'd1,1'b0,32'd0,        1'b0); // 4th digit
    add(1'b0,1'b1,1'b1,4'h2, 2'd2,1'b0,4'd1,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'h5, 2'd2,1'b0,4'd1,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'h0, 2'd2,1'b0,4'd1,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'h0, 2'd2,1'b0,4'd1,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'hE, 2'd0,1'b0,4'd1,1'b1,32'd2500,     1'b0); // commit
    add(1'b0,1'b1,1'b0,4'h0, 2'd0,1'b0,4'd1,1'b0,32'd2500,     1'b0); // no re-entry
    add(1'b0,1'b1,1'b1,4'h5, 2'd0,1'b0,4'd1,1'b0,32'd2500,     1'b0); // ignored
    add(1'b0,1'b0,1'b0,4'h0, 2'd0,1'b0,4'd1,1'b0,32'd2500,     1'b0); // card out
    add(1'b0,1'b1,1'b0,4'h0, 2'd1,1'b0,4'd1,1'b0,32'd2500,     1'b0);
    add(1'b0,1'b1,1'b1,4'h1, 2'd1,1'b1,4'd1,1'b0,32'd2500,     1'b0);
    add(1'b0,1'b1,1'b1,4'h2, 2'd1,1'b1,4'd2,1'b0,32'd2500,     1'b0);
    add(1'b0,1'b1,1'b1,4'h3, 2'd1,1'b1,4'd3,1'b0,32'd2500,     1'b0);
    add(1'b0,1'b1,1'b1,4'h4, 2'd2,1'b1,4'd4,1'b0,32'd2500,     1'b0);
    add(1'b0,1'b1,1'b1,4'h4, 2'd2,1'b0,4'd4,1'b0,32'd2500,     1'b0);
    add(1'b0,1'b1,1'b1,4'hC, 2'd2,1'b0,4'd4,1'b0,32'd2500,     1'b0); // clear
    add(1'b0,1'b1,1'b1,4'hE, 2'd2,1'b0,4'd4,1'b0,32'd2500,     1'b1); // empty enter
    add(1'b0,1'b1,1'b1,4'h7, 2'd2,1'b0,4'd4,1'b0,32'd2500,     1'b0);
    add(1'b0,1'b1,1'b1,4'hE, 2'd0,1'b0,4'd4,1'b1,32'd7,        1'b0);
    add(1'b0,1'b0,1'b0,4'h0, 2'd0,1'b0,4'd4,1'b0,32'd7,        1'b0);
    add(1'b0,1'b1,1'b0,4'h0, 2'd1,1'b0,4'd4,1'b0,32'd7,        1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0,1'b1,1'b1,4'h0, (i == 3) ? 2'd2 : 2'd1,1'b1,4'd0,1'b0,32'd7,1'b0);
    for (int i = 0; i < 10; i++)
      add(1'b0,1'b1,1'b1,4'h9, 2'd2,1'b0,4'd0,1'b0,32'd7,(i == 9) ? 1'b1 : 1'b0);
    add(1'b0,1'b1,1'b1,4'hE, 2'd0,1'b0,4'd0,1'b1,32'd999999999,1'b0);
    add(1'b0,1'b0,1'b0,4'h0, 2'd0,1'b0,4'd0,1'b0,32'd999999999,1'b0);
    add(1'b0,1'b1,1'b0,4'h0, 2'd1,1'b0,4'd0,1'b0,32'd999999999,1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0,1'b1,1'b1,4'h5, (i == 3) ? 2'd2 : 2'd1,1'b1,4'd5,1'b0,32'd999999999,1'b0);
    add(1'b0,1'b1,1'b1,4'h8, 2'd2,1'b0,4'd5,1'b0,32'd999999999,1'b0);
    add(1'b0,1'b0,1'b1,4'h3, 2'd0,1'b0,4'd5,1'b0,32'd999999999,1'b0); // abort + key
    add(1'b0,1'b1,1'b0,4'h0, 2'd1,1'b0,4'd5,1'b0,32'd999999999,1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0,1'b1,1'b1,4'h1, (i == 3) ? 2'd2 : 2'd1,1'b1,4'd1,1'b0,32'd999999999,1'b0);
    add(1'b0,1'b1,1'b1,4'h6, 2'd2,1'b0,4'd1,1'b0,32'd999999999,1'b0);
    add(1'b1,1'b1,1'b1,4'h2, 2'd0,1'b0,4'd0,1'b0,32'd0,        1'b0); // rst mid-amount
    add(1'b0,1'b1,1'b0,4'h0, 2'd1,1'b0,4'd0,1'b0,32'd0,        1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0,1'b1,1'b1,4'h9, (i == 3) ? 2'd2 : 2'd1,1'b1,4'd9,1'b0,32'd0,1'b0);
    add(1'b0,1'b1,1'b1,4'h3, 2'd2,1'b0,4'd9,1'b0,32'd0,        1'b0);
    add(1'b0,1'b1,1'b1,4'hE, 2'd0,1'b0,4'd9,1'b1,32'd3,        1'b0); // acc restarted at 0

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].card, vecs[i].stb, vecs[i].key);
      chk_all($sformatf("v%0d", i), vecs[i].e_est, vecs[i].e_dstb, vecs[i].e_dig,
              vecs[i].e_mstb, vecs[i].e_monto, vecs[i].e_inv);
    end

    // Hand sequence: fill the amount to its digit limit, clear, then commit a
    // single digit -- the clear must also reset the digit count.
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 4'h2);
    chk("h.in_monto", {30'd0, estado}, 32'd2);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 4'h8);
    step(1'b0, 1'b1, 1'b1, 4'h8);
    chk("h.limit_inv", {31'd0, tecla_invalida}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 4'hC);
    chk("h.clear_noinv", {31'd0, tecla_invalida}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 4'h1);
    chk("h.after_clear_ok", {31'd0, tecla_invalida}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 4'hA);
    chk("h.key_a_inv", {31'd0, tecla_invalida}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 4'hE);
    chk("h.commit_stb", {31'd0, monto_stb}, 32'd1);
    chk("h.commit_val", monto, 32'd1);
    chk("h.commit_est", {30'd0, estado}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h0);
    chk("h.stb_one_cycle", {31'd0, monto_stb}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/captura_teclado.md
CAPTURA_TECLADO -- requirements
Module: captura_teclado

Interface
REQ-001 SHALL have parameter TECLA_ENTER, default 4'hE, key code that commits the amount.
REQ-002 SHALL have parameter TECLA_BORRAR, default 4'hC, key code that clears the amount being entered.
REQ-003 SHALL have parameter MAX_DIGITOS, default 9, maximum number of decimal digits in an amount.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port tarjeta_recibida, input, 1, card present; low aborts any session.
REQ-007 SHALL have port tecla, input, 4, raw keypad code (0-9 digits, A-F control).
REQ-008 SHALL have port tecla_stb, input, 1, one-cycle strobe qualifying tecla.
REQ-009 SHALL have port digito, output, 4, PIN digit forwarded to the controller.
REQ-010 SHALL have port digito_stb, output, 1, one-cycle strobe qualifying digito.
REQ-011 SHALL have port monto, output, 32, binary amount for the controller, held until the next commit.
REQ-012 SHALL have port monto_stb, output, 1, one-cycle strobe qualifying monto.
REQ-013 SHALL have port tecla_invalida, output, 1, one-cycle pulse flagging a rejected key.
REQ-014 SHALL have port estado, output, 2, current FSM state (ESPERA=0, PIN=1, MONTO=2).

Function
REQ-015 SHALL implement the FSM states ESPERA, PIN and MONTO.
REQ-016 SHALL, in ESPERA, ignore tecla_stb and move to PIN on the cycle after tarjeta_recibida=1.
REQ-017 SHALL, in PIN, forward each key 0-9: digito=tecla and digito_stb=1 exactly one cycle after tecla_stb (registered).
REQ-018 SHALL, in PIN, count forwarded digits (3-bit counter); after the 4th digit, move to MONTO and clear the counter.
REQ-019 SHALL, in PIN, reject keys A-F: no digito_stb, no count change, tecla_invalida=1 one cycle later.
REQ-020 SHALL, in MONTO, accumulate key 0-9 as acc = acc*10 + tecla (32-bit, unsigned) and increment the digit count.
REQ-021 SHALL, in MONTO, reject a digit once the count equals MAX_DIGITOS: acc unchanged, tecla_invalida pulse.
REQ-022 SHALL, in MONTO, on TECLA_BORRAR, clear acc and the count to 0, with no pulse.
REQ-023 SHALL, in MONTO, on TECLA_ENTER with count>0, load monto=acc and pulse monto_stb one cycle later, then go to ESPERA.
REQ-024 SHALL, in MONTO, on TECLA_ENTER with count=0, pulse tecla_invalida, leave monto_stb at 0 and stay in MONTO.
REQ-025 SHALL, in MONTO, treat any other A-F key as invalid (tecla_invalida pulse, acc unchanged).
REQ-026 SHALL return to ESPERA from PIN or MONTO on the cycle after tarjeta_recibida=0, clearing acc and counts; a same-cycle tecla_stb is discarded with no pulse.
REQ-027 SHALL, after a commit, stay in ESPERA while tarjeta_recibida is still 1 until that input goes low and high again (one transaction per card insertion).
REQ-028 SHALL never assert digito_stb and monto_stb in the same cycle; at most one strobe output is high per cycle.
REQ-029 SHALL accept back-to-back tecla_stb on consecutive cycles with no key lost.

Reset
REQ-030 SHALL, when rst=1 at a rising clk edge, set estado=ESPERA, digito=0, digito_stb=0, monto=0, monto_stb=0, tecla_invalida=0, acc=0 and all counters to 0.
REQ-031 SHALL give rst priority over all other inputs, including mid-PIN or mid-amount entry, with no pending strobe emitted afterward.

Verification
REQ-032 SHALL pass: card in; keys 3,7,2,1 -> four digito_stb pulses carrying 3,7,2,1, each 1 cycle after its key; estado goes 1 then 2.
REQ-033 SHALL pass: in MONTO, keys 2,5,0,0,E -> monto=2500, single monto_stb pulse; estado=0.
REQ-034 SHALL pass: in MONTO, keys 9 entered 10 times, then E -> 10th key gives tecla_invalida; monto=999999999.
REQ-035 SHALL pass: in MONTO, keys 4,C,E -> tecla_invalida on E, no monto_stb; then 7,E -> monto=7.
REQ-036 SHALL pass: in PIN, key B -> tecla_invalida, no digito_stb, count unchanged.
REQ-037 SHALL pass: mid-amount tarjeta_recibida=0 or rst=1 -> estado=0, no monto_stb; a later amount entry starts from acc=0.
